cdr_oversampler_pd: RTL and testbench

- Single-clock, parametrised successor to the dual-edge CDR sampler.
- Oversamples Serial at OSR samples per UI and synchronises it into data_clock.
- Picks a programmable data sample point and an edge point half a UI away, producing Dn, Dn_1 and Pn with a valid strobe.
- Adds Alexander bang-bang early/late decisions, optional 3-sample majority voting, and a handshaked phase-step interface for the loop filter.

---
 rtl/cdr_oversampler_pd.sv | 160 ++++++++++++++++
 tb/tb_cdr_oversampler_pd.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdr_oversampler_pd.sv
// ============================================================================
// Module      : cdr_oversampler_pd
// Description : Oversampling CDR front end with programmable sample point,
//               Alexander early/late phase detector and phase-step handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdr_oversampler_pd #(
  parameter int OSR         = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit VOTE_EN     = 1'b0
) (
  input  logic                    data_clock,
  input  logic                    Reset,
  input  logic                    Serial,
  input  logic                    phase_up,
  input  logic                    phase_dn,
  output logic                    phase_ack,
  output logic                    Dn,
  output logic                    Dn_1,
  output logic                    Pn,
  output logic                    sample_valid,
  output logic                    early,
  output logic                    late,
  output logic [$clog2(OSR)-1:0]  phase
);

  localparam int              PH_W   = $clog2(OSR);
  localparam logic [PH_W-1:0] C_HALF = PH_W'(OSR / 2);
  localparam logic [PH_W-1:0] C_LAST = PH_W'(OSR - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [PH_W-1:0]        r_cnt;
  logic [PH_W-1:0]        r_dp;
  logic                   r_skip;
  logic                   r_edge;
  logic                   r_dn;
  logic                   r_dn_1;
  logic                   r_pn;
  logic                   r_valid;
  logic                   r_early;
  logic                   r_late;
  logic                   r_ack;

  logic                   w_s;
  logic                   w_d;
  logic                   w_edge_smp;
  logic [PH_W-1:0]        w_ep;
  logic [PH_W-1:0]        w_dp_inc;
  logic [PH_W-1:0]        w_dp_dec;
  logic                   w_data_evt;
  logic                   w_edge_evt;
  logic                   w_step_up;
  logic                   w_step_dn;

  generate
    if (SYNC_STAGES == 1) begin : g_sync_one
      always_ff @(posedge data_clock) begin
        if (Reset) r_sync <= '0;
        else       r_sync <= Serial;
      end
    end else begin : g_sync_chain
      always_ff @(posedge data_clock) begin
        if (Reset) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], Serial};
      end
    end
  endgenerate

  assign w_s = r_sync[SYNC_STAGES-1];

  // Vote mode centres both decisions on w1, so data and edge paths stay aligned.
  generate
    if (VOTE_EN) begin : g_vote
      logic r_w1;
      logic r_w2;
      always_ff @(posedge data_clock) begin
        if (Reset) begin
          r_w1 <= 1'b0;
          r_w2 <= 1'b0;
        end else begin
          r_w1 <= w_s;
          r_w2 <= r_w1;
        end
      end
      assign w_d        = (w_s & r_w1) | (w_s & r_w2) | (r_w1 & r_w2);
      assign w_edge_smp = r_w1;
    end else begin : g_novote
      assign w_d        = w_s;
      assign w_edge_smp = w_s;
    end
  endgenerate

  assign w_ep       = (r_dp >= C_HALF) ? (r_dp - C_HALF) : (r_dp + C_HALF);
  assign w_dp_inc   = (r_dp == C_LAST) ? '0 : (r_dp + PH_W'(1));
  assign w_dp_dec   = (r_dp == '0) ? C_LAST : (r_dp - PH_W'(1));
  // After an up-step the new dp equals the next cnt; r_skip suppresses that
  // immediate match so the interval stretches to OSR+1 instead of doubling.
  assign w_data_evt = (r_cnt == r_dp) && !r_skip;
  assign w_edge_evt = (r_cnt == w_ep);
  assign w_step_up  = w_data_evt && phase_up && !phase_dn;
  assign w_step_dn  = w_data_evt && phase_dn && !phase_up;

  always_ff @(posedge data_clock) begin
    if (Reset) begin
      r_cnt   <= '0;
      r_dp    <= C_HALF;
      r_skip  <= 1'b0;
      r_edge  <= 1'b0;
      r_dn    <= 1'b0;
      r_dn_1  <= 1'b0;
      r_pn    <= 1'b0;
      r_valid <= 1'b0;
      r_early <= 1'b0;
      r_late  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_cnt   <= (r_cnt == C_LAST) ? '0 : (r_cnt + PH_W'(1));
      r_skip  <= w_step_up;
      r_valid <= 1'b0;
      r_early <= 1'b0;
      r_late  <= 1'b0;
      r_ack   <= 1'b0;

      if (w_edge_evt) begin
        r_edge <= w_edge_smp;
      end

      if (w_data_evt) begin
        r_dn_1  <= r_dn;
        r_dn    <= w_d;
        r_pn    <= r_edge;
        r_valid <= 1'b1;
        r_early <= (r_dn != w_d) && (r_edge == r_dn);
        r_late  <= (r_dn != w_d) && (r_edge == w_d);
      end

      if (w_step_up) begin
        r_dp  <= w_dp_inc;
        r_ack <= 1'b1;
      end else if (w_step_dn) begin
        r_dp  <= w_dp_dec;
        r_ack <= 1'b1;
      end
    end
  end

  assign Dn           = r_dn;
  assign Dn_1         = r_dn_1;
  assign Pn           = r_pn;
  assign sample_valid = r_valid;
  assign early        = r_early;
  assign late         = r_late;
  assign phase_ack    = r_ack;
  assign phase        = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_cdr_oversampler_pd.sv
// ============================================================================
// Module      : tb_cdr_oversampler_pd
// Description : Directed self-checking bench for cdr_oversampler_pd (OSR=4),
//               one instance without and one with majority voting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdr_oversampler_pd;

  logic       clk;
  logic       Reset;
  logic       Serial;
  logic       phase_up;
  logic       phase_dn;

  logic       nv_ack, nv_dn, nv_dn1, nv_pn, nv_valid, nv_early, nv_late;
  logic [1:0] nv_phase;
  logic       vt_ack, vt_dn, vt_dn1, vt_pn, vt_valid, vt_early, vt_late;
  logic [1:0] vt_phase;

  int checks = 0;
  int errors = 0;

  cdr_oversampler_pd #(.OSR(4), .SYNC_STAGES(2), .VOTE_EN(1'b0)) u_nv (
    .data_clock(clk), .Reset(Reset), .Serial(Serial),
    .phase_up(phase_up), .phase_dn(phase_dn), .phase_ack(nv_ack),
    .Dn(nv_dn), .Dn_1(nv_dn1), .Pn(nv_pn), .sample_valid(nv_valid),
    .early(nv_early), .late(nv_late), .phase(nv_phase)
  );

  cdr_oversampler_pd #(.OSR(4), .SYNC_STAGES(2), .VOTE_EN(1'b1)) u_vt (
    .data_clock(clk), .Reset(Reset), .Serial(Serial),
    .phase_up(phase_up), .phase_dn(phase_dn), .phase_ack(vt_ack),
    .Dn(vt_dn), .Dn_1(vt_dn1), .Pn(vt_pn), .sample_valid(vt_valid),
    .early(vt_early), .late(vt_late), .phase(vt_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the reset-release cycle (cycle 0).
  task automatic apply_reset;
    Reset    = 1'b1;
    Serial   = 1'b0;
    phase_up = 1'b0;
    phase_dn = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    Reset    = 1'b1;
    phase_up = 1'b0;
    phase_dn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Serial = i[0];
      tick();
    end
    checks++;
    if ({nv_dn, nv_dn1, nv_pn, nv_valid, nv_early, nv_late, nv_ack} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outs_nv: got %b expected 0000000",
               {nv_dn, nv_dn1, nv_pn, nv_valid, nv_early, nv_late, nv_ack});
    end
    checks++;
    if (nv_phase !== 2'd2) begin
      errors++;
      $display("FAIL reset_phase_nv: got %0d expected 2", nv_phase);
    end
    checks++;
    if ({vt_dn, vt_dn1, vt_pn, vt_valid, vt_early, vt_late, vt_ack} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outs_vt: got %b expected 0000000",
               {vt_dn, vt_dn1, vt_pn, vt_valid, vt_early, vt_late, vt_ack});
    end
    checks++;
    if (vt_phase !== 2'd2) begin
      errors++;
      $display("FAIL reset_phase_vt: got %0d expected 2", vt_phase);
    end
    Serial = 1'b0;
    Reset  = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      checks++;
      if (nv_valid !== ((c % 4) == 3)) begin
        errors++;
        $display("FAIL release_strobe c=%0d: got %b expected %b", c, nv_valid, (c % 4) == 3);
      end
      tick();
    end
  endtask

  task automatic test_constant_one;
    apply_reset();
    Serial = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) begin
        checks++;
        if ({nv_dn, nv_pn, nv_early, nv_late} !== 4'b1010) begin
          errors++;
          $display("FAIL first_rise_nv: got %b expected 1010", {nv_dn, nv_pn, nv_early, nv_late});
        end
      end
      if (c >= 11 && (c % 4) == 3) begin
        checks++;
        if ({nv_valid, nv_dn, nv_dn1, nv_pn, nv_early, nv_late} !== 6'b111100) begin
          errors++;
          $display("FAIL const1_nv c=%0d: got %b expected 111100", c,
                   {nv_valid, nv_dn, nv_dn1, nv_pn, nv_early, nv_late});
        end
        checks++;
        if ({vt_valid, vt_dn, vt_dn1, vt_pn, vt_early, vt_late} !== 6'b111100) begin
          errors++;
          $display("FAIL const1_vt c=%0d: got %b expected 111100", c,
                   {vt_valid, vt_dn, vt_dn1, vt_pn, vt_early, vt_late});
        end
      end
      tick();
    end
  endtask

  task automatic test_early_late;
    for (int r = 2; r <= 3; r++) begin
      logic [4:0] exp_el;
      exp_el = (r == 2) ? 5'b10101 : 5'b10010;
      apply_reset();
      for (int c = 0; c <= 8; c++) begin
        Serial = (c >= r);
        if (c == 3) begin
          checks++;
          if ({nv_valid, nv_early, nv_late} !== 3'b100) begin
            errors++;
            $display("FAIL no_transition r=%0d: got %b expected 100", r, {nv_valid, nv_early, nv_late});
          end
        end
        if (c == 7) begin
          checks++;
          if ({nv_dn, nv_dn1, nv_pn, nv_early, nv_late} !== exp_el) begin
            errors++;
            $display("FAIL early_late r=%0d: got %b expected %b", r,
                     {nv_dn, nv_dn1, nv_pn, nv_early, nv_late}, exp_el);
          end
        end
        if (c == 8) begin
          checks++;
          if ({nv_valid, nv_early, nv_late} !== 3'b000) begin
            errors++;
            $display("FAIL off_strobe r=%0d: got %b expected 000", r, {nv_valid, nv_early, nv_late});
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_phase_step;
    logic       exp_valid, exp_ack;
    logic [1:0] exp_phase;
    apply_reset();
    for (int c = 0; c <= 25; c++) begin
      if (nv_ack) begin
        phase_up = 1'b0;
        phase_dn = 1'b0;
      end
      if (c == 0 || c == 8) phase_up = 1'b1;
      if (c == 17)          phase_dn = 1'b1;
      exp_valid = (c == 3) || (c == 8) || (c == 12) || (c == 17) || (c == 21) || (c == 24);
      exp_ack   = (c == 3) || (c == 12) || (c == 21);
      exp_phase = (c < 3) ? 2'd2 : (c < 12) ? 2'd3 : (c < 21) ? 2'd0 : 2'd3;
      checks++;
      if ({nv_valid, nv_ack, nv_phase} !== {exp_valid, exp_ack, exp_phase}) begin
        errors++;
        $display("FAIL phase_step c=%0d: got valid/ack/phase %b/%b/%0d expected %b/%b/%0d",
                 c, nv_valid, nv_ack, nv_phase, exp_valid, exp_ack, exp_phase);
      end
      tick();
    end
    phase_up = 1'b0;
    phase_dn = 1'b0;
  endtask

  task automatic test_both_requests;
    apply_reset();
    phase_up = 1'b1;
    phase_dn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({nv_ack, nv_phase, nv_valid} !== {1'b0, 2'd2, ((c % 4) == 3)}) begin
        errors++;
        $display("FAIL both_req c=%0d: got ack/phase/valid %b/%0d/%b expected 0/2/%b",
                 c, nv_ack, nv_phase, nv_valid, (c % 4) == 3);
      end
      tick();
    end
    phase_up = 1'b0;
    phase_dn = 1'b0;
  endtask

  task automatic test_glitch;
    apply_reset();
    for (int c = 0; c <= 16; c++) begin
      Serial = (c == 3) || (c == 8);
      if (c == 7 || c == 11 || c == 15) begin
        checks++;
        if ({vt_valid, vt_dn} !== 2'b10) begin
          errors++;
          $display("FAIL glitch_vote c=%0d: got valid/Dn %b/%b expected 1/0", c, vt_valid, vt_dn);
        end
        checks++;
        if ({nv_valid, nv_dn} !== {1'b1, (c == 11)}) begin
          errors++;
          $display("FAIL glitch_novote c=%0d: got valid/Dn %b/%b expected 1/%b", c, nv_valid, nv_dn, c == 11);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    Serial   = 1'b1;
    phase_up = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      if (nv_ack) phase_up = 1'b0;
      if (c == 9) begin
        checks++;
        if ({nv_phase, nv_dn} !== {2'd3, 1'b1}) begin
          errors++;
          $display("FAIL pre_reset: got phase/Dn %0d/%b expected 3/1", nv_phase, nv_dn);
        end
        Reset = 1'b1;
      end
      tick();
    end
    Reset = 1'b0;
    checks++;
    if ({nv_dn, nv_dn1, nv_pn, nv_valid, nv_early, nv_late, nv_ack} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset_outs: got %b expected 0000000",
               {nv_dn, nv_dn1, nv_pn, nv_valid, nv_early, nv_late, nv_ack});
    end
    checks++;
    if ({nv_phase, vt_phase} !== {2'd2, 2'd2}) begin
      errors++;
      $display("FAIL mid_reset_phase: got %0d/%0d expected 2/2", nv_phase, vt_phase);
    end
    for (int r = 0; r <= 8; r++) begin
      checks++;
      if (nv_valid !== (r == 3 || r == 7)) begin
        errors++;
        $display("FAIL mid_reset_strobe r=%0d: got %b expected %b", r, nv_valid, r == 3 || r == 7);
      end
      tick();
    end
  endtask

  initial begin
    Reset    = 1'b1;
    Serial   = 1'b0;
    phase_up = 1'b0;
    phase_dn = 1'b0;
    tick();
    test_reset();
    test_constant_one();
    test_early_late();
    test_phase_step();
    test_both_requests();
    test_glitch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
